// File: rtl/bcd_to_bin_seq.sv
// Packed BCD to binary converter (reverse double-dabble); optional hex display via BCD2BIN_HEX_EN.
// Latency: done pulses W+1 edges after the accepting edge (1 edge for a bad digit).
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   bin_out
`ifdef BCD2BIN_HEX_EN
  ,
  output logic [6:0]            HEX1,
  output logic [6:0]            HEX0
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [2*W-1:0]  r;
  logic [2*W-1:0]  r_sh;
  logic [2*W-1:0]  r_nx;
  logic [CW-1:0]   cnt;
  logic            bad;

  always_comb begin
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // One iteration: shift right, then pull every upper digit that reached >= 8 back by 3.
  always_comb begin
    r_sh = r >> 1;
    r_nx = r_sh;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sh[W + 4*d + 3]) r_nx[W + 4*d +: 4] = r_sh[W + 4*d +: 4] - 4'd3;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      r       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      busy <= (state == CONV);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (bad) begin
              err     <= 1'b1;
              bin_out <= '0;
              state   <= DONE;
            end else begin
              r     <= {bcd_in, {W{1'b0}}};
              cnt   <= '0;
              err   <= 1'b0;
              state <= CONV;
            end
          end
        end
        CONV: begin
          r   <= r_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            bin_out <= r_nx[W-1:0];
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_HEX_EN
  logic [7:0] hex_src;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    hex_src = 8'(bin_out);
    HEX1    = err ? 7'h7F : seg7(hex_src[7:4]);
    HEX0    = err ? 7'h7F : seg7(hex_src[3:0]);
  end
`endif

endmodule
